csoc_cmd_master: RTL

Synthesizable host-side engine for the part tester's UART command protocol. It takes one command descriptor, serialises it into bytes for a uart_tx instance, and for get commands collects the returned ASCII bit stream from a uart_rx instance. It generalises vector width and adds a free-run timer, error reporting and an optional receive timeout. It sits between a local controller (CPU or self-test FSM) and the uart_tx/uart_rx pair that talks to part_tester.

---
 rtl/csoc_cmd_master_if.sv | 29 ++
 rtl/csoc_cmd_master.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/csoc_cmd_master_if.sv
// Command/UART/response bundle for csoc_cmd_master: master is the engine side,
// slave is the controller plus uart_tx/uart_rx side.
interface csoc_cmd_master_if #(
  parameter int unsigned MAX_BITS = 64
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [7:0]          cmd_op;
  logic [15:0]         cmd_len;
  logic [MAX_BITS-1:0] cmd_data;
  logic                tx_start;
  logic [7:0]          tx_data;
  logic                tx_ready;
  logic                rx_rcv;
  logic [7:0]          rx_data;
  logic                rsp_valid;
  logic [MAX_BITS-1:0] rsp_data;
  logic [2:0]          rsp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, tx_ready, rx_rcv, rx_data,
    output cmd_ready, tx_start, tx_data, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_len, cmd_data, tx_ready, rx_rcv, rx_data,
    input  cmd_ready, tx_start, tx_data, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/csoc_cmd_master.sv
// Host-side UART command engine for part_tester: serialises one descriptor and collects
// returned ASCII bits. Optional receive timeout enabled by defining CMD_TIMEOUT_EN.
module csoc_cmd_master #(
  parameter int unsigned MAX_BITS       = 64,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input logic                clk,
  input logic                rst,
  csoc_cmd_master_if.master  bus_io
);

  localparam int unsigned IdxW = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  localparam logic [7:0] OpR = 8'h72;
  localparam logic [7:0] OpS = 8'h73;
  localparam logic [7:0] OpG = 8'h67;
  localparam logic [7:0] OpE = 8'h65;
  localparam logic [7:0] OpI = 8'h69;
  localparam logic [7:0] OpO = 8'h6F;
  localparam logic [7:0] OpF = 8'h66;

  if (MAX_BITS < 1 || MAX_BITS > 1024 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("csoc_cmd_master: parameter out of range");
  end

  typedef enum logic [3:0] {
    StIdle, StHdrOp, StHdrHi, StHdrLo, StTxBits, StRxBits, StRun, StTxDone, StResp
  } state_e;

  typedef enum logic [1:0] {TxWait, TxHold, TxDrain} tx_phase_e;

  state_e              state_q, state_d;
  tx_phase_e           phase_q, phase_d;
  logic [7:0]          op_q, op_d;
  logic [15:0]         len_q, len_d;
  logic [MAX_BITS-1:0] data_q, data_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         cyc_q, cyc_d;
  logic                tx_start_q, tx_start_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [MAX_BITS-1:0] rsp_data_q, rsp_data_d;
  logic [2:0]          rsp_err_q, rsp_err_d;
  logic                rx_rcv_q;

  logic                is_tx, byte_done, rx_rise, op_bits, op_known;
  logic [7:0]          tx_byte;
  logic [15:0]         cnt_inc;
  logic [IdxW-1:0]     idx;

`ifdef CMD_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;
`endif

  assign idx     = cnt_q[IdxW-1:0];
  assign cnt_inc = cnt_q + 16'd1;
  assign rx_rise = bus_io.rx_rcv & ~rx_rcv_q;
  assign op_bits  = bus_io.cmd_op inside {OpS, OpE, OpG, OpI};
  assign op_known = op_bits || (bus_io.cmd_op inside {OpR, OpO, OpF});
  assign is_tx    = state_q inside {StHdrOp, StHdrHi, StHdrLo, StTxBits, StTxDone};

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    op_d       = op_q;
    len_d      = len_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    byte_done  = 1'b0;
    tx_byte    = 8'h00;
    cyc_d      = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
`ifdef CMD_TIMEOUT_EN
    to_cnt_d   = '0;
`endif

    unique case (state_q)
      StHdrOp:  tx_byte = op_q;
      StHdrHi:  tx_byte = len_q[15:8];
      StHdrLo:  tx_byte = len_q[7:0];
      StTxBits: tx_byte = data_q[idx] ? 8'h31 : 8'h30;
      StTxDone: tx_byte = 8'h64;
      default:  tx_byte = 8'h00;
    endcase

    // Run time is measured from the edge on which tx_start falls.
    if (tx_start_q && !bus_io.tx_ready) cyc_d = '0;

    if (is_tx) begin
      unique case (phase_q)
        TxWait: begin
          if (bus_io.tx_ready) begin
            tx_start_d = 1'b1;
            tx_data_d  = tx_byte;
            phase_d    = TxHold;
          end
        end
        TxHold: begin
          if (!bus_io.tx_ready) begin
            tx_start_d = 1'b0;
            phase_d    = TxDrain;
          end
        end
        TxDrain: begin
          if (bus_io.tx_ready) begin
            phase_d   = TxWait;
            byte_done = 1'b1;
          end
        end
        default: phase_d = TxWait;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (bus_io.cmd_valid) begin
          op_d       = bus_io.cmd_op;
          len_d      = bus_io.cmd_len;
          data_d     = bus_io.cmd_data;
          rsp_data_d = '0;
          rsp_err_d  = '0;
          cnt_d      = '0;
          phase_d    = TxWait;
          if (!op_known || (op_bits && ({16'd0, bus_io.cmd_len} > MAX_BITS))) begin
            rsp_err_d[0] = 1'b1;
            state_d      = StResp;
          end else begin
            state_d = StHdrOp;
          end
        end
      end
      StHdrOp: begin
        if (byte_done) begin
          if (op_q == OpR)      state_d = StResp;
          else if (op_q == OpF) state_d = StRun;
          else                  state_d = StHdrHi;
        end
      end
      StHdrHi: if (byte_done) state_d = StHdrLo;
      StHdrLo: begin
        if (byte_done) begin
          cnt_d = '0;
          if (len_q == 16'd0 || op_q == OpO) state_d = StResp;
          else if (op_q inside {OpS, OpE})   state_d = StTxBits;
          else                               state_d = StRxBits;
        end
      end
      StTxBits: begin
        if (byte_done) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = StResp;
        end
      end
      StRxBits: begin
        if (rx_rise) begin
          rsp_data_d[idx] = (bus_io.rx_data == 8'h31);
          if (bus_io.rx_data != 8'h31 && bus_io.rx_data != 8'h30) rsp_err_d[1] = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = StResp;
        end
`ifdef CMD_TIMEOUT_EN
        else if (to_cnt_q + 32'd1 >= TIMEOUT_CYCLES) begin
          rsp_err_d[2] = 1'b1;
          state_d      = StResp;
        end else begin
          to_cnt_d = to_cnt_q + 32'd1;
        end
`endif
      end
      StRun:    if (cyc_q >= len_q) state_d = StTxDone;
      StTxDone: if (byte_done) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      phase_q    <= TxWait;
      op_q       <= '0;
      len_q      <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      cyc_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= '0;
      rx_rcv_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      op_q       <= op_d;
      len_q      <= len_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      rx_rcv_q   <= bus_io.rx_rcv;
    end
  end

`ifdef CMD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`endif

  assign bus_io.cmd_ready = (state_q == StIdle);
  assign bus_io.tx_start  = tx_start_q;
  assign bus_io.tx_data   = tx_data_q;
  assign bus_io.rsp_valid = (state_q == StResp);
  assign bus_io.rsp_data  = rsp_data_q;
  assign bus_io.rsp_err   = rsp_err_q;

endmodule
